// File: rtl/div_unit_if.sv
// Execute-stage handshake between the pipeline and the iterative divider.
// master = pipeline/hazard side, slave = divider.
interface div_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            start_i;
   logic [1:0]      op_i;
   logic [XLEN-1:0] a_i;
   logic [XLEN-1:0] b_i;
   logic            flush_i;
   logic            stall_o;
   logic            done_o;
   logic [XLEN-1:0] result_o;

   modport master (
      output start_i, op_i, a_i, b_i, flush_i,
      input  stall_o, done_o, result_o
   );

   modport slave (
      input  start_i, op_i, a_i, b_i, flush_i,
      output stall_o, done_o, result_o
   );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; divide-by-zero and signed overflow resolve in one cycle.
module div_unit #(
   parameter int unsigned XLEN = 32
) (
   input logic       clk,
   input logic       rst_n,
   div_unit_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(XLEN + 1);
   localparam int unsigned DW    = 2 * XLEN;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_d;

   logic [CNT_W-1:0] cnt;
   logic [DW-1:0]    rq;
   logic [XLEN-1:0]  bmag;
   logic [XLEN-1:0]  result;
   logic             is_rem_q;
   logic             neg_q;

   logic             accept;
   logic             op_signed;
   logic             sa;
   logic             sb;
   logic             bzero;
   logic             ovf;
   logic             fast;
   logic [XLEN-1:0]  amag;
   logic [XLEN-1:0]  bmag_c;
   logic [XLEN-1:0]  fast_res;

   logic [XLEN:0]    partial;
   logic             borrow;
   logic [XLEN-1:0]  rem_new;
   logic [DW-1:0]    rq_step;
   logic [XLEN-1:0]  sel;
   logic [XLEN-1:0]  fixed;
   logic             last;

   // Operand decode: magnitudes and the single-cycle special cases
   always_comb begin
      accept    = bus.start_i & ~bus.flush_i;
      op_signed = ~bus.op_i[0];
      sa        = op_signed & bus.a_i[XLEN-1];
      sb        = op_signed & bus.b_i[XLEN-1];
      amag      = sa ? (~bus.a_i + XLEN'(1)) : bus.a_i;
      bmag_c    = sb ? (~bus.b_i + XLEN'(1)) : bus.b_i;
      bzero     = (bus.b_i == '0);
      ovf       = op_signed & (bus.a_i == MIN_NEG) & (bus.b_i == '1);
      fast      = bzero | ovf;
      if (bzero) begin
         fast_res = bus.op_i[1] ? bus.a_i : '1;
      end else begin
         fast_res = bus.op_i[1] ? '0 : MIN_NEG;
      end
   end

   // One restoring step; the partial remainder needs XLEN+1 bits after the shift
   always_comb begin
      partial = rq[DW-1:XLEN-1];
      borrow  = (partial < {1'b0, bmag});
      rem_new = borrow ? partial[XLEN-1:0] : XLEN'(partial - {1'b0, bmag});
      rq_step = {rem_new, rq[XLEN-2:0], ~borrow};
      sel     = is_rem_q ? rq_step[DW-1:XLEN] : rq_step[XLEN-1:0];
      fixed   = neg_q ? (~sel + XLEN'(1)) : sel;
      last    = (cnt == CNT_W'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE: if (accept) state_d = fast ? DONE : CALC;
         CALC: if (last) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.flush_i) state_d = IDLE;
   end

   always_comb begin
      bus.stall_o = 1'b0;
      bus.done_o  = 1'b0;
      case (state)
         IDLE:    bus.stall_o = accept;
         CALC:    bus.stall_o = ~bus.flush_i;
         DONE:    bus.done_o  = ~bus.flush_i;
         default: ;
      endcase
   end

   assign bus.result_o = result;

   // Datapath: latch on accept, iterate in CALC, register the sign-fixed result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         rq       <= '0;
         bmag     <= '0;
         result   <= '0;
         is_rem_q <= 1'b0;
         neg_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  is_rem_q <= bus.op_i[1];
                  neg_q    <= bus.op_i[1] ? sa : (sa ^ sb);
                  bmag     <= bmag_c;
                  rq       <= {{XLEN{1'b0}}, amag};
                  cnt      <= CNT_W'(XLEN);
                  if (fast) result <= fast_res;
               end
            end
            CALC: begin
               if (!bus.flush_i) begin
                  rq  <= rq_step;
                  cnt <= cnt - CNT_W'(1);
                  if (last) result <= fixed;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors, random ops vs. an arithmetic
// reference, and flush / reset / back-to-back timing sequences.
module tb_div_unit;
   logic clk;
   logic rst_n;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   div_unit_if #(.XLEN(32)) bus ();

   div_unit #(.XLEN(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic        fast;
      string       name;
   } vec_t;

   vec_t vecs[18];

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: RV32M semantics from plain signed/unsigned arithmetic
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      int signed sa;
      int signed sb;
      logic      ovf;
      sa  = $signed(a);
      sb  = $signed(b);
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         2'd0:    return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
         2'd1:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
         2'd2:    return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic is_fast(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
      return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // Sample each cycle at mid-period until done_o; lat is cycles after the start cycle
   task automatic wait_done(input int max_cyc, output int lat, output int stalls,
                            output logic [31:0] res);
      lat    = -1;
      stalls = 0;
      res    = '0;
      for (int k = 0; k <= max_cyc; k++) begin
         #3;
         if (bus.stall_o) stalls++;
         if (bus.done_o) begin
            lat = k;
            res = bus.result_o;
            break;
         end
         tick();
      end
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int stalls, output logic [31:0] res,
                         output int done_at);
      tick();
      bus.start_i = 1'b1;
      bus.op_i    = op;
      bus.a_i     = a;
      bus.b_i     = b;
      wait_done(40, lat, stalls, res);
      done_at = cyc;
   endtask

   task automatic check_op(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp, input logic fast);
      int          lat;
      int          stalls;
      int          done_at;
      logic [31:0] res;
      run_op(op, a, b, lat, stalls, res, done_at);
      check({name, " result"}, res, exp);
      check({name, " latency"}, 32'(lat), fast ? 32'd1 : 32'd33);
      check({name, " stall_cycles"}, 32'(stalls), fast ? 32'd1 : 32'd33);
   endtask

   initial begin
      int          lat;
      int          stalls;
      int          d1;
      int          d2;
      int          dones;
      logic [31:0] res;
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;

      vecs[0]  = '{2'd1, 32'd100,        32'd7,          32'd14,         1'b0, "divu_100_7"};
      vecs[1]  = '{2'd3, 32'd100,        32'd7,          32'd2,          1'b0, "remu_100_7"};
      vecs[2]  = '{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, "div_m7_2"};
      vecs[3]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, "rem_m7_2"};
      vecs[4]  = '{2'd0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0, "div_7_m2"};
      vecs[5]  = '{2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, "rem_7_m2"};
      vecs[6]  = '{2'd1, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, "divu_5_0"};
      vecs[7]  = '{2'd3, 32'd5,          32'd0,          32'd5,          1'b1, "remu_5_0"};
      vecs[8]  = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, "div_ovf"};
      vecs[9]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1, "rem_ovf"};
      vecs[10] = '{2'd0, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, "div_5_0"};
      vecs[11] = '{2'd2, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1'b1, "rem_m5_0"};
      vecs[12] = '{2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          1'b0, "divu_max_maxm1"};
      vecs[13] = '{2'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          1'b0, "remu_max_maxm1"};
      vecs[14] = '{2'd3, 32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  1'b0, "remu_maxm1_max"};
      vecs[15] = '{2'd1, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, "divu_max_1"};
      vecs[16] = '{2'd0, 32'h8000_0000,  32'd2,          32'hC000_0000,  1'b0, "div_min_2"};
      vecs[17] = '{2'd1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, "divu_min_max"};

      rst_n       = 1'b0;
      bus.start_i = 1'b0;
      bus.op_i    = 2'd0;
      bus.a_i     = '0;
      bus.b_i     = '0;
      bus.flush_i = 1'b0;

      #3;
      check("reset stall_o", 32'(bus.stall_o), 32'd0);
      check("reset done_o", 32'(bus.done_o), 32'd0);
      check("reset result_o", bus.result_o, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         check_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].fast);
         tick();
         bus.start_i = 1'b0;
      end

      for (int i = 0; i < 40; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         case ($urandom_range(0, 9))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = -32'($urandom_range(1, 15));
            3: begin
               rb = 32'hFFFF_FFFF;
               if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000;
            end
            4: begin
               ra = 32'($urandom_range(0, 200)) - 32'd100;
               rb = $urandom;
            end
            default: rb = $urandom;
         endcase
         check_op("random", rop, ra, rb, model(rop, ra, rb), is_fast(rop, ra, rb));
         if ($urandom_range(0, 1) == 1) begin
            tick();
            bus.start_i = 1'b0;
         end
      end
      tick();
      bus.start_i = 1'b0;

      // Flush mid-CALC, then a fresh op the next cycle
      tick();
      bus.start_i = 1'b1;
      bus.op_i    = 2'd1;
      bus.a_i     = 32'd1000;
      bus.b_i     = 32'd3;
      dones       = 0;
      for (int k = 0; k < 10; k++) begin
         #3;
         if (bus.done_o) dones++;
         tick();
      end
      bus.flush_i = 1'b1;
      #3;
      check("flush stall_o low", 32'(bus.stall_o), 32'd0);
      if (bus.done_o) dones++;
      tick();
      bus.flush_i = 1'b0;
      bus.a_i     = 32'd9;
      bus.b_i     = 32'd3;
      wait_done(40, lat, stalls, res);
      check("flush early done_o", 32'(dones), 32'd0);
      check("post-flush latency", 32'(lat), 32'd33);
      check("post-flush result", res, 32'd3);
      check("post-flush stall_cycles", 32'(stalls), 32'd33);
      tick();
      bus.start_i = 1'b0;

      // Flush while in DONE suppresses done_o and leaves result_o alone
      tick();
      bus.start_i = 1'b1;
      bus.op_i    = 2'd1;
      bus.a_i     = 32'd5;
      bus.b_i     = 32'd0;
      tick();
      bus.flush_i = 1'b1;
      #3;
      check("done-flush done_o", 32'(bus.done_o), 32'd0);
      check("done-flush stall_o", 32'(bus.stall_o), 32'd0);
      check("done-flush result_o", bus.result_o, 32'hFFFF_FFFF);
      tick();
      bus.flush_i = 1'b0;
      bus.start_i = 1'b0;

      // Back-to-back: second op's done_o exactly 34 cycles after the first
      run_op(2'd1, 32'd1000, 32'd7, lat, stalls, res, d1);
      check("b2b first result", res, 32'd142);
      run_op(2'd3, 32'd1000, 32'd7, lat, stalls, res, d2);
      check("b2b second result", res, 32'd6);
      check("b2b spacing", 32'(d2 - d1), 32'd34);
      tick();
      bus.start_i = 1'b0;

      // Asynchronous reset in the middle of a DIV
      tick();
      bus.start_i = 1'b1;
      bus.op_i    = 2'd0;
      bus.a_i     = 32'hFFFF_FF00;
      bus.b_i     = 32'd3;
      for (int k = 0; k < 5; k++) tick();
      rst_n       = 1'b0;
      bus.start_i = 1'b0;
      #1;
      check("midop reset result_o", bus.result_o, 32'd0);
      check("midop reset done_o", 32'(bus.done_o), 32'd0);
      check("midop reset stall_o", 32'(bus.stall_o), 32'd0);
      tick();
      rst_n = 1'b1;
      check_op("div_20_4 after reset", 2'd0, 32'd20, 32'd4, 32'd5, 1'b0);
      tick();
      bus.start_i = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
